// File: rtl/mux_sel_pkg.sv
// Shared constants and state type for the mux select sequencer.
// The PARITY state exists only when MUX_SEL_PARITY_EN is defined.
package mux_sel_pkg;

    localparam int WORD_W = 32;
    localparam int SEL_W  = 5;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SEND   = 2'd2
`ifdef MUX_SEL_PARITY_EN
        , ST_PARITY = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/mux_sel_settle_cnt.sv
// Settle-delay down counter: loadable, decrements while enabled, flags zero.
module mux_sel_settle_cnt
    import mux_sel_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             cnt_zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/mux_sel_sequencer.sv
// Walks an external 32:1 select tree LSB first and streams each bit over a
// valid/ready link. Define MUX_SEL_PARITY_EN to append an even-parity bit.
module mux_sel_sequencer
    import mux_sel_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] word_q,
    output logic [SEL_W-1:0]  sel,
    input  logic              mux_out,
    output logic              ser_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE_CYC);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WORD_W - 1);

    state_t           state;
    logic             load_acc;
    logic             accept;
    logic             last_bit;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    assign load_acc = load_valid && load_ready;
    assign accept   = ser_valid && ser_ready;
    assign last_bit = (sel == SEL_LAST);

    // A load settles for SETTLE_CYC+1 cycles; later bits for SETTLE_CYC cycles.
    assign cnt_load = load_acc ||
                      (accept && (state == ST_SEND) && !last_bit && (SETTLE_CYC != 0));
    assign cnt_val  = load_acc ? SETTLE_V : (SETTLE_V - 1'b1);
    assign cnt_dec  = (state == ST_SETTLE);

    mux_sel_settle_cnt u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt_zero (cnt_zero)
    );

`ifdef MUX_SEL_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (load_acc) begin
            parity_q <= ^load_data;
        end
    end

    assign ser_data = ser_valid && ((state == ST_PARITY) ? parity_q : mux_out);
`else
    assign ser_data = ser_valid && mux_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            word_q     <= '0;
            sel        <= '0;
            ser_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    load_ready <= 1'b1;
                    if (load_acc) begin
                        word_q     <= load_data;
                        sel        <= '0;
                        state      <= ST_SETTLE;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_zero) begin
                        state     <= ST_SEND;
                        ser_valid <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (ser_ready) begin
                        if (!last_bit) begin
                            sel <= sel + 1'b1;
                            if (SETTLE_CYC != 0) begin
                                state     <= ST_SETTLE;
                                ser_valid <= 1'b0;
                            end
                        end else begin
`ifdef MUX_SEL_PARITY_EN
                            state <= ST_PARITY;
`else
                            state      <= ST_IDLE;
                            ser_valid  <= 1'b0;
                            busy       <= 1'b0;
                            load_ready <= 1'b1;
                            done       <= 1'b1;
`endif
                        end
                    end
                end
`ifdef MUX_SEL_PARITY_EN
                ST_PARITY: begin
                    if (ser_ready) begin
                        state      <= ST_IDLE;
                        ser_valid  <= 1'b0;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                        done       <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_sel_sequencer.md
MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 1: idle cycles after each select change before the bit is presented; legal range 0..15.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port load_valid, input, 1 bit: a 32-bit word is offered.
REQ-005 SHALL have port load_ready, output, 1 bit: high only in IDLE.
REQ-006 SHALL have port load_data, input, 32 bits: the offered word.
REQ-007 SHALL have port word_q, output, 32 bits: the held word, driving the external 32:1 select tree data input.
REQ-008 SHALL have port sel, output, 5 bits: the index driven to the external select tree.
REQ-009 SHALL have port mux_out, input, 1 bit: the external select tree output.
REQ-010 SHALL have port ser_data, output, 1 bit: the serial bit, mux_out (or parity) when ser_valid, else 0.
REQ-011 SHALL have port ser_valid, output, 1 bit: ser_data is presented.
REQ-012 SHALL have port ser_ready, input, 1 bit: the downstream consumer accepts.
REQ-013 SHALL have port busy, output, 1 bit: high in any state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse after the final bit is accepted.

Function
REQ-015 SHALL implement states IDLE, SETTLE and SEND, plus PARITY when REQ-027 applies.
REQ-016 SHALL accept a load when load_valid and load_ready are both high at the edge (cycle N); at that edge word_q takes load_data, sel takes 0 and the settle counter takes SETTLE_CYC.
REQ-017 SHALL move to SEND at N+1 when SETTLE_CYC is 0, and otherwise to SETTLE for exactly SETTLE_CYC cycles before SEND.
REQ-018 SHALL hold ser_valid high in SEND (and PARITY), with sel and ser_data stable until ser_valid and ser_ready are both high.
REQ-019 SHALL, on acceptance in SEND with sel < 31, increment sel and go to SETTLE, or directly to SEND when SETTLE_CYC is 0.
REQ-020 SHALL, on acceptance in SEND with sel == 31, go to IDLE and pulse done the next cycle; sel does not wrap and stays at 31 in IDLE.
REQ-021 SHALL transmit the LSB first; with ser_ready held high each bit takes 1+SETTLE_CYC cycles and a word takes 32*(1+SETTLE_CYC) cycles.
REQ-022 SHALL ignore load_valid while busy, leaving word_q unchanged.
REQ-023 SHALL allow a load to be accepted in the same cycle that done is high, since the block is already in IDLE.

Reset
REQ-024 SHALL, while rst_n is low, force state to IDLE, word_q to 0, sel to 0, ser_valid to 0, ser_data to 0, done to 0, busy to 0, load_ready to 0 and the settle counter to 0.
REQ-025 SHALL set load_ready to 1 on the first edge after rst_n deasserts.
REQ-026 SHALL discard any partially sent word when reset is asserted mid-word, with no done pulse.

Configuration
REQ-027 SHALL, when MUX_SEL_PARITY_EN is defined, register the even parity (XOR of load_data) at load and, after bit 31 is accepted, enter PARITY presenting that bit under the same handshake; done then follows parity acceptance, and a word is 33 bits.
REQ-028 SHALL, when MUX_SEL_PARITY_EN is undefined, contain no parity register or PARITY state, and a word is 32 bits.

Structure
REQ-029 SHALL take from shared package mux_sel_pkg the constants WORD_W=32 and SEL_W=5 and the state enumeration type.
REQ-030 SHALL contain the external 32:1 select tree outside this block, never instantiated within it.
REQ-031 SHALL place the settle counter in sub-module mux_sel_settle_cnt, with load, count-zero flag and 4-bit width.

Verification
REQ-032 SHALL check: SETTLE_CYC=1, load 0xA5A5_0F0F, ser_ready=1 -> ser_data sequence 1,1,1,1,0,0,0,0,... LSB first, first ser_valid at N+2, done at N+65.
REQ-033 SHALL check: SETTLE_CYC=0, load 0xFFFF_FFFF -> ser_valid continuous for 32 cycles from N+1, done at N+33.
REQ-034 SHALL check: ser_ready held low 10 cycles at sel=5 -> sel stays 5, ser_data stays bit 5, no bit lost.
REQ-035 SHALL check: load_valid pulsed with 0x1234_5678 while busy -> load ignored, original word completes unchanged.
REQ-036 SHALL check: rst_n pulsed low at sel=17 -> all outputs 0 immediately, no done pulse, then load_ready=1 after release.
REQ-037 SHALL check: MUX_SEL_PARITY_EN defined, load 0x0000_0007 -> 33rd bit is 1, done after parity acceptance.
